inst_encoder: RTL and testbench

Streaming RV32I instruction encoder. It accepts decoded fields (format class, rd, rs1, rs2, funct3, funct7, sign-extended immediate) over a valid/ready handshake. It packs them into 32-bit instruction words and emits each word with an incrementing instruction-memory address. It sits between the self-test/boot program generator and the instruction-memory write port, and is the inverse of the decode stage: for every legal input, decoding out_inst returns the input rd/rs1/rs2/imm.

---
 rtl/inst_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_inst_encoder.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words and
// stamps each word with an incrementing instruction-memory address.
module inst_encoder #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000,
    parameter int unsigned           DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_fmt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_err
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    // True when v survives truncation to an n-bit two's-complement value.
    function automatic logic fits(
        input logic signed [DATA_WIDTH-1:0] v,
        input int unsigned                  n
    );
        logic [DATA_WIDTH-1:0] hi;
        hi = v >>> (n - 1);
        return (hi == '0) || (hi == '1);
    endfunction

    logic [31:0] enc_inst;
    logic        enc_err;
    logic        shift;
    logic [DATA_WIDTH-1:0] imm;

    assign imm = in_imm;

    always_comb begin
        enc_inst = NOP;
        enc_err  = 1'b1;
        shift    = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
        unique case (in_fmt)
            4'd0: begin
                enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
                enc_err  = 1'b0;
            end
            4'd1: begin
                if (shift) begin
                    enc_inst = {in_funct7, imm[4:0], in_rs1, in_funct3, in_rd, OP_I};
                    enc_err  = |imm[DATA_WIDTH-1:5];
                end else begin
                    enc_inst = {imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
                    enc_err  = !fits(imm, 12);
                end
            end
            4'd2: begin
                enc_inst = {imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
                enc_err  = !fits(imm, 12);
            end
            4'd3: begin
                enc_inst = {imm[11:5], in_rs2, in_rs1, in_funct3, imm[4:0], OP_STORE};
                enc_err  = !fits(imm, 12);
            end
            4'd4: begin
                enc_inst = {imm[12], imm[10:5], in_rs2, in_rs1, in_funct3,
                            imm[4:1], imm[11], OP_BR};
                enc_err  = !fits(imm, 13) || imm[0];
            end
            4'd5: begin
                enc_inst = {imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
                enc_err  = !fits(imm, 12);
            end
            4'd6: begin
                enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], in_rd, OP_JAL};
                enc_err  = !fits(imm, 21) || imm[0];
            end
            4'd7: begin
                enc_inst = {imm[31:12], in_rd, OP_LUI};
                enc_err  = |imm[11:0];
            end
            4'd8: begin
                enc_inst = {imm[31:12], in_rd, OP_AUIPC};
                enc_err  = |imm[11:0];
            end
            default: begin
                enc_inst = NOP;
                enc_err  = 1'b1;
            end
        endcase
    end

    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_inst_q, out_inst_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                  out_err_q, out_err_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [31:0]           skid_inst_q, skid_inst_d;
    logic [ADDR_WIDTH-1:0] skid_addr_q, skid_addr_d;
    logic                  skid_err_q, skid_err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  in_ready_q, in_ready_d;
    logic                  in_xfer, out_free;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_inst_d   = out_inst_q;
        out_addr_d   = out_addr_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_addr_d  = skid_addr_q;
        skid_err_d   = skid_err_q;
        addr_d       = addr_q;
        if (restart) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            addr_d       = PC_ADDR;
        end else begin
            if (in_xfer) begin
                addr_d = addr_q + ADDR_WIDTH'(4);
            end
            // Skid full implies in_ready low, so no new word competes with it.
            if (out_free) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_inst_d   = skid_inst_q;
                    out_addr_d   = skid_addr_q;
                    out_err_d    = skid_err_q;
                    skid_valid_d = 1'b0;
                end else if (in_xfer) begin
                    out_valid_d = 1'b1;
                    out_inst_d  = enc_inst;
                    out_addr_d  = addr_q;
                    out_err_d   = enc_err;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (in_xfer) begin
                skid_valid_d = 1'b1;
                skid_inst_d  = enc_inst;
                skid_addr_d  = addr_q;
                skid_err_d   = enc_err;
            end
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_inst_q   <= '0;
            out_addr_q   <= PC_ADDR;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= '0;
            skid_addr_q  <= '0;
            skid_err_q   <= 1'b0;
            addr_q       <= PC_ADDR;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            out_addr_q   <= out_addr_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_addr_q  <= skid_addr_d;
            skid_err_q   <= skid_err_d;
            addr_q       <= addr_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: scoreboard model of the encoder plus directed
// vectors; a second instance based near the top of memory covers wrap.
`timescale 1ns/1ps
module tb_inst_encoder;

    localparam logic [31:0] PC  = 32'h8000_0000;
    localparam logic [31:0] PC2 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset, restart, in_valid, out_ready;
    logic [3:0]  in_fmt;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        in_ready, out_valid, out_err;
    logic [31:0] out_inst, out_addr;
    logic        in_ready2, out_valid2, out_err2;
    logic [31:0] out_inst2, out_addr2;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk(clk), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err)
    );

    inst_encoder #(.PC_ADDR(PC2)) dut_wrap (
        .clk(clk), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_inst(out_inst2), .out_addr(out_addr2), .out_err(out_err2)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } word_t;

    typedef struct packed {
        logic [3:0]  f;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fld_t;

    word_t       exp_q[$];
    word_t       log_q[$];
    logic [31:0] log2_q[$];
    fld_t        fq[$];
    logic [31:0] m_addr = PC;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic bit [31:0] at(input bit [31:0] x, input int sh);
        return x << sh;
    endfunction

    function automatic bit in_s(input int v, input int bits);
        return v >= -(1 <<< (bits - 1)) && v < (1 <<< (bits - 1));
    endfunction

    // Reference encoder: places each field by shifting the value into position.
    function automatic word_t ref_enc(input fld_t x, input logic [31:0] a);
        bit [31:0] u, w, base;
        int        v;
        bit        e;
        u = x.imm;
        v = int'(x.imm);
        base = at(x.rd, 7) | at(x.f3, 12) | at(x.rs1, 15);
        e = 1'b0;
        case (x.f)
            4'd0: w = 32'h33 | base | at(x.rs2, 20) | at(x.f7, 25);
            4'd1: begin
                if (x.f3 == 3'd1 || x.f3 == 3'd5) begin
                    w = 32'h13 | base | at(u & 31, 20) | at(x.f7, 25);
                    e = (u >> 5) != 0;
                end else begin
                    w = 32'h13 | base | at(u & 32'hFFF, 20);
                    e = !in_s(v, 12);
                end
            end
            4'd2: begin w = 32'h03 | base | at(u & 32'hFFF, 20); e = !in_s(v, 12); end
            4'd3: begin
                w = 32'h23 | at(u & 31, 7) | at(x.f3, 12) | at(x.rs1, 15)
                    | at(x.rs2, 20) | at((u >> 5) & 127, 25);
                e = !in_s(v, 12);
            end
            4'd4: begin
                w = 32'h63 | at((u >> 11) & 1, 7) | at((u >> 1) & 15, 8)
                    | at(x.f3, 12) | at(x.rs1, 15) | at(x.rs2, 20)
                    | at((u >> 5) & 63, 25) | at((u >> 12) & 1, 31);
                e = !in_s(v, 13) || (u & 1) != 0;
            end
            4'd5: begin
                w = 32'h67 | at(x.rd, 7) | at(x.rs1, 15) | at(u & 32'hFFF, 20);
                e = !in_s(v, 12);
            end
            4'd6: begin
                w = 32'h6F | at(x.rd, 7) | at((u >> 12) & 255, 12)
                    | at((u >> 11) & 1, 20) | at((u >> 1) & 1023, 21)
                    | at((u >> 20) & 1, 31);
                e = !in_s(v, 21) || (u & 1) != 0;
            end
            4'd7: begin w = 32'h37 | at(x.rd, 7) | (u & 32'hFFFF_F000); e = (u & 32'hFFF) != 0; end
            4'd8: begin w = 32'h17 | at(x.rd, 7) | (u & 32'hFFFF_F000); e = (u & 32'hFFF) != 0; end
            default: begin w = 32'h13; e = 1'b1; end
        endcase
        return '{inst: w, addr: a, err: e};
    endfunction

    task automatic chk_reset(input string nm);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_in_ready"}, in_ready, 1);
        chk({nm, "_out_inst"}, out_inst, 0);
        chk({nm, "_out_addr"}, out_addr, PC);
        chk({nm, "_out_err"}, out_err, 0);
        chk({nm, "_wrap_addr"}, out_addr2, PC2);
    endtask

    // Compare process: mid-cycle, check outputs against the model, then
    // advance the model for the handshakes the coming edge will perform.
    always @(negedge clk) begin
        fld_t x;
        if (!reset) begin
            exp_q.delete();
            m_addr = PC;
            chk_reset("rst");
        end else begin
            chk("in_ready", in_ready, exp_q.size() < 2);
            chk("out_valid", out_valid, exp_q.size() > 0);
            chk("wrap_in_ready", in_ready2, exp_q.size() < 2);
            chk("wrap_out_valid", out_valid2, exp_q.size() > 0);
            if (out_valid && exp_q.size() > 0) begin
                chk("out_inst", out_inst, exp_q[0].inst);
                chk("out_addr", out_addr, exp_q[0].addr);
                chk("out_err", out_err, exp_q[0].err);
                chk("wrap_inst", out_inst2, exp_q[0].inst);
                chk("wrap_addr", out_addr2, exp_q[0].addr - PC + PC2);
                chk("wrap_err", out_err2, exp_q[0].err);
            end
            if (restart) begin
                exp_q.delete();
                m_addr = PC;
            end else begin
                if (out_valid && out_ready) begin
                    log_q.push_back('{inst: out_inst, addr: out_addr, err: out_err});
                    log2_q.push_back(out_addr2);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (in_valid && in_ready) begin
                    x = '{f: in_fmt, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                          f3: in_funct3, f7: in_funct7, imm: in_imm};
                    exp_q.push_back(ref_enc(x, m_addr));
                    m_addr = m_addr + 32'd4;
                end
            end
        end
    end

    task automatic drive(input fld_t x);
        in_fmt = x.f; in_rd = x.rd; in_rs1 = x.rs1; in_rs2 = x.rs2;
        in_funct3 = x.f3; in_funct7 = x.f7; in_imm = x.imm;
    endtask

    task automatic send(input logic [3:0] f, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        bit ok;
        int n;
        drive('{f: f, rd: rd, rs1: rs1, rs2: rs2, f3: f3, f7: f7, imm: imm});
        in_valid = 1'b1;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic chk_log(input int i, input logic [31:0] inst,
                           input logic [31:0] addr, input logic err, input string nm);
        if (i >= log_q.size()) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got no word, expected word %0d", nm, i);
        end else begin
            chk({nm, "_inst"}, log_q[i].inst, inst);
            chk({nm, "_addr"}, log_q[i].addr, addr);
            chk({nm, "_err"}, log_q[i].err, err);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        return (v[bits-1]) ? (v | ~((32'd1 << bits) - 1)) : v;
    endfunction

    function automatic fld_t rand_fld();
        fld_t x;
        int   v;
        x.f   = 4'($urandom_range(0, 8));
        x.rd  = 5'($urandom);
        x.rs1 = 5'($urandom);
        x.rs2 = 5'($urandom);
        x.f3  = 3'($urandom);
        x.f7  = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        v     = int'($urandom_range(0, 4095)) - 2048;
        x.imm = 32'(v);
        case (x.f)
            4'd0: x.imm = $urandom;
            4'd1: if (x.f3 == 3'd1 || x.f3 == 3'd5) x.imm = 32'($urandom_range(0, 31));
            4'd4: x.imm = 32'((int'($urandom_range(0, 8191)) - 4096) & ~1);
            4'd6: x.imm = 32'((int'($urandom_range(0, 2097151)) - 1048576) & ~1);
            4'd7, 4'd8: x.imm = $urandom & 32'hFFFF_F000;
            default: ;
        endcase
        return x;
    endfunction

    // Independent decoder used to confirm the words round-trip.
    task automatic chk_decode(input int i);
        fld_t        x;
        logic [31:0] w, d;
        x = fq[i];
        w = log_q[i].inst;
        chk("dec_err", log_q[i].err, 0);
        if (x.f != 4'd3 && x.f != 4'd4) chk("dec_rd", w[11:7], x.rd);
        if (x.f < 4'd6) chk("dec_rs1", w[19:15], x.rs1);
        if (x.f == 4'd0 || x.f == 4'd3 || x.f == 4'd4) chk("dec_rs2", w[24:20], x.rs2);
        d = 32'd0;
        case (w[6:0])
            7'h13: d = (w[14:12] == 3'd1 || w[14:12] == 3'd5) ? {27'd0, w[24:20]}
                                                             : sx({20'd0, w[31:20]}, 12);
            7'h03, 7'h67: d = sx({20'd0, w[31:20]}, 12);
            7'h23: d = sx({20'd0, w[31:25], w[11:7]}, 12);
            7'h63: d = sx({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
            7'h6F: d = sx({11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
            7'h37, 7'h17: d = {w[31:12], 12'd0};
            default: d = 32'd0;
        endcase
        if (x.f != 4'd0) chk("dec_imm", d, x.imm);
    endtask

    initial begin
        reset = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive('0);
        idle(2);
        chk_reset("reset");
        reset = 1'b1;

        out_ready = 1'b1;
        log_q.delete();
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        idle(3);
        chk("addi_count", log_q.size(), 1);
        chk_log(0, 32'h0050_0093, PC, 1'b0, "addi");

        pulse_restart();
        log_q.delete();
        send(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        send(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        idle(3);
        chk_log(0, 32'hFE20_8EE3, PC, 1'b0, "beq");
        chk_log(1, 32'h1234_52B7, PC + 4, 1'b0, "lui");

        pulse_restart();
        log_q.delete();
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        send(4'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        send(4'd12, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        idle(3);
        chk("err_count", log_q.size(), 3);
        chk_log(0, 32'h8000_0093, PC, 1'b1, "i_range");
        chk_log(1, 32'h0020_00EF, PC + 4, 1'b1, "jal_odd");
        chk_log(2, 32'h0000_0013, PC + 8, 1'b1, "bad_fmt");

        pulse_restart();
        log_q.delete();
        log2_q.delete();
        out_ready = 1'b0;
        fork
            begin
                send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
                send(4'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
                send(4'd1, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_held_inst", out_inst, 32'h0010_0093);
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);
        chk("bp_count", log_q.size(), 3);
        chk_log(0, 32'h0010_0093, PC, 1'b0, "bp0");
        chk_log(1, 32'h0020_0113, PC + 4, 1'b0, "bp1");
        chk_log(2, 32'h0030_0193, PC + 8, 1'b0, "bp2");
        if (log2_q.size() == 3) begin
            chk("wrap0", log2_q[0], 32'hFFFF_FFF8);
            chk("wrap1", log2_q[1], 32'hFFFF_FFFC);
            chk("wrap2", log2_q[2], 32'h0000_0000);
        end else begin
            chk("wrap_count", log2_q.size(), 3);
        end

        pulse_restart();
        out_ready = 1'b0;
        send(4'd1, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
        drive('{f: 4'd1, rd: 5'd5, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, f7: 7'd0, imm: 32'd5});
        in_valid = 1'b1;
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rs_out_valid", out_valid, 0);
        chk("rs_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        log_q.delete();
        out_ready = 1'b1;
        send(4'd1, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
        idle(3);
        chk("rs_count", log_q.size(), 1);
        chk_log(0, 32'h0060_0313, PC, 1'b0, "rs_next");

        pulse_restart();
        log_q.delete();
        fq.delete();
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    fld_t x;
                    x = rand_fld();
                    fq.push_back(x);
                    send(x.f, x.rd, x.rs1, x.rs2, x.f3, x.f7, x.imm);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 1) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(6);
        chk("rand_count", log_q.size(), fq.size());
        for (int i = 0; i < fq.size() && i < log_q.size(); i++) chk_decode(i);

        log_q.delete();
        out_ready = 1'b0;
        send(4'd1, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        send(4'd1, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        reset = 1'b0;
        #1;
        chk_reset("midrst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        idle(3);
        chk("midrst_drained", log_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
